// File: rtl/ad_bus_responder.sv
// Responder end of an 8-bit multiplexed address/data bus backed by an NREG x DW register file.
// Optional feature: define ADDR_AUTOINC_EN to step the address after each committed write and each completed read.
module ad_bus_responder #(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          ad_n,
    input  logic          wr_n,
    input  logic          rd_n,
    inout  wire  [DW-1:0] io_port,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [DW-1:0] loc_wdata,
    output logic          bus_wr,
    output logic [AW-1:0] bus_waddr,
    output logic [DW-1:0] bus_wdata,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    function automatic logic inRange(input logic [AW-1:0] a);
        return (32'(a) < NREG);
    endfunction

`ifdef ADDR_AUTOINC_EN
    function automatic logic [AW-1:0] incAddr(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        if (32'(a) >= NREG - 1) begin
            r = {AW{1'b0}};
        end else begin
            r = a + {{(AW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction
`endif

    // Control strobes packed as {cs, ad, wr, rd}; presets of 1 mean "bus inactive".
    logic [3:0]    ctlMeta_r;
    logic [3:0]    ctlSync_r;
    logic          wrPrev_r;
    logic [DW-1:0] ioSample_r;

    state_t        state_r;
    state_t        nextState_s;
    logic [AW-1:0] addrQ_r;
    logic          busWr_r;
    logic [AW-1:0] busWaddr_r;
    logic [DW-1:0] busWdata_r;
    logic          protoErr_r;
    logic          ioOe_r;
    logic [DW-1:0] ioDout_r;
    logic [DW-1:0] regFile_r [NREG];

    logic          csSync_s;
    logic          adSync_s;
    logic          wrSync_s;
    logic          rdSync_s;
    logic          wrRise_s;
    logic          addrCommit_s;
    logic          dataCommit_s;
    logic          writeHit_s;
    logic          readDone_s;
    logic          protoSet_s;
    logic [DW-1:0] readData_s;

    assign csSync_s   = ctlSync_r[3];
    assign adSync_s   = ctlSync_r[2];
    assign wrSync_s   = ctlSync_r[1];
    assign rdSync_s   = ctlSync_r[0];
    assign wrRise_s   = wrSync_s & ~wrPrev_r;
    assign writeHit_s = dataCommit_s & inRange(addrQ_r);

    // Two-flop synchronisers for the strobes, single register stage for the bus value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctlMeta_r  <= 4'hF;
            ctlSync_r  <= 4'hF;
            wrPrev_r   <= 1'b1;
            ioSample_r <= {DW{1'b0}};
        end else begin
            ctlMeta_r  <= {cs_n, ad_n, wr_n, rd_n};
            ctlSync_r  <= ctlMeta_r;
            wrPrev_r   <= wrSync_s;
            ioSample_r <= io_port;
        end
    end

    // Bus cycle decode: deselect and strobe collisions override every state.
    always_comb begin
        nextState_s  = state_r;
        addrCommit_s = 1'b0;
        dataCommit_s = 1'b0;
        readDone_s   = 1'b0;
        protoSet_s   = 1'b0;
        if (csSync_s) begin
            nextState_s = IDLE;
        end else if (!wrSync_s && !rdSync_s) begin
            nextState_s = IDLE;
            protoSet_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!wrSync_s) begin
                        nextState_s = adSync_s ? WRITE : ADDR;
                    end else if (!rdSync_s && adSync_s) begin
                        nextState_s = READ;
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                ADDR: begin
                    if (wrRise_s) begin
                        nextState_s  = IDLE;
                        addrCommit_s = 1'b1;
                    end else begin
                        nextState_s = ADDR;
                    end
                end
                WRITE: begin
                    if (wrRise_s) begin
                        nextState_s  = IDLE;
                        dataCommit_s = 1'b1;
                    end else begin
                        nextState_s = WRITE;
                    end
                end
                READ: begin
                    if (rdSync_s) begin
                        nextState_s = IDLE;
                        readDone_s  = 1'b1;
                    end else begin
                        nextState_s = READ;
                    end
                end
                default: begin
                    nextState_s = IDLE;
                end
            endcase
        end
    end

    // Read data source; unmapped addresses read as zero.
    always_comb begin
        readData_s = {DW{1'b0}};
        if (inRange(addrQ_r)) begin
            readData_s = regFile_r[addrQ_r];
        end else begin
            readData_s = {DW{1'b0}};
        end
    end

    // State, address pointer, write report and read driver registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addrQ_r    <= {AW{1'b0}};
            busWr_r    <= 1'b0;
            busWaddr_r <= {AW{1'b0}};
            busWdata_r <= {DW{1'b0}};
            protoErr_r <= 1'b0;
            ioOe_r     <= 1'b0;
            ioDout_r   <= {DW{1'b0}};
        end else begin
            state_r    <= nextState_s;
            busWr_r    <= writeHit_s;
            protoErr_r <= protoErr_r | protoSet_s;
            ioOe_r     <= (nextState_s == READ);
            ioDout_r   <= readData_s;
            if (writeHit_s) begin
                busWaddr_r <= addrQ_r;
                busWdata_r <= ioSample_r;
            end
            if (addrCommit_s) begin
                addrQ_r <= ioSample_r[AW-1:0];
            end
`ifdef ADDR_AUTOINC_EN
            else if (writeHit_s || readDone_s) begin
                addrQ_r <= incAddr(addrQ_r);
            end
`endif
        end
    end

    // Register file: the bus commit is written last so it wins an address clash with the local port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regFile_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (loc_we && inRange(loc_addr)) begin
                regFile_r[loc_addr] <= loc_wdata;
            end
            if (writeHit_s) begin
                regFile_r[addrQ_r] <= ioSample_r;
            end
        end
    end

    assign io_port   = ioOe_r ? ioDout_r : {DW{1'bz}};
    assign bus_wr    = busWr_r;
    assign bus_waddr = busWaddr_r;
    assign bus_wdata = busWdata_r;
    assign proto_err = protoErr_r;

endmodule

// File: tb/tb_ad_bus_responder.sv
// Directed, table-driven bench for ad_bus_responder. NREG is set to 12 so that a 4-bit
// address can actually land outside the register file; a pull-up makes a released bus read 8'hFF.
module tb_ad_bus_responder;

    localparam int DW   = 8;
    localparam int NREG = 12;
    localparam int AW   = 4;
    localparam logic [7:0] RELEASED = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       ad_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       loc_we = 1'b0;
    logic [3:0] loc_addr = 4'h0;
    logic [7:0] loc_wdata = 8'h00;
    logic       bus_wr;
    logic [3:0] bus_waddr;
    logic [7:0] bus_wdata;
    logic       proto_err;
    wire  [7:0] io_port;

    logic       tbOe = 1'b0;
    logic [7:0] tbDrv = 8'h00;
    int         nChecks = 0;
    int         nErrors = 0;
    int         pulseCnt = 0;
    logic [3:0] lastWaddr = 4'h0;
    logic [7:0] lastWdata = 8'h00;

    assign io_port = tbOe ? tbDrv : 8'bz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (io_port[i]);
    end

    always #5 clk = ~clk;

    ad_bus_responder #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .io_port(io_port), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .bus_wr(bus_wr), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .proto_err(proto_err)
    );

    always @(negedge clk) begin
        if (bus_wr) begin
            pulseCnt  = pulseCnt + 1;
            lastWaddr = bus_waddr;
            lastWdata = bus_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic busAddr(input logic [7:0] a);
        cs_n = 1'b0; ad_n = 1'b0; tbDrv = a; tbOe = 1'b1; wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1;
        tick(4);
        tbOe = 1'b0; ad_n = 1'b1; cs_n = 1'b1;
        tick(3);
    endtask

    task automatic busWrite(input logic [7:0] d);
        cs_n = 1'b0; ad_n = 1'b1; tbDrv = d; tbOe = 1'b1; wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1;
        tick(4);
        tbOe = 1'b0; cs_n = 1'b1;
        tick(3);
    endtask

    // Checks drive timing: released after 2 edges, driven at the 3rd, released again 3 edges after rd_n rises.
    task automatic busRead(input string name, input logic [7:0] want);
        cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0;
        tick(2);
        check({name, "_pre"}, 32'(io_port), 32'(RELEASED));
        tick(1);
        check(name, 32'(io_port), 32'(want));
        rd_n = 1'b1;
        tick(2);
        check({name, "_hold"}, 32'(io_port), 32'(want));
        tick(1);
        check({name, "_rel"}, 32'(io_port), 32'(RELEASED));
        cs_n = 1'b1;
        tick(3);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         expPulses;
        logic [7:0] expRead;
    } vec_t;

    vec_t vecs [6];
    int   p0;

    initial begin
        vecs[0] = '{8'h05, 8'hA7, 1, 8'hA7};
        vecs[1] = '{8'h00, 8'h3C, 1, 8'h3C};
        vecs[2] = '{8'h0B, 8'hFE, 1, 8'hFE};
        vecs[3] = '{8'h1F, 8'h55, 0, 8'h00};
        vecs[4] = '{8'h0C, 8'h66, 0, 8'h00};
        vecs[5] = '{8'hF3, 8'h5A, 1, 8'h5A};

        tick(3);
        check("rst_io", 32'(io_port), 32'(RELEASED));
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_buswr", 32'(bus_wr), 32'd0);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < NREG; i++) begin
            busAddr(8'(i));
            busRead($sformatf("rst_reg%0d", i), 8'h00);
        end

        for (int i = 0; i < 6; i++) begin
            p0 = pulseCnt;
            busAddr(vecs[i].addr);
            busWrite(vecs[i].data);
            check($sformatf("v%0d_pulses", i), 32'(pulseCnt - p0), 32'(vecs[i].expPulses));
            if (vecs[i].expPulses == 1) begin
                check($sformatf("v%0d_waddr", i), 32'(lastWaddr), 32'(vecs[i].addr[3:0]));
                check($sformatf("v%0d_wdata", i), 32'(lastWdata), 32'(vecs[i].data));
            end
            busAddr(vecs[i].addr);
            busRead($sformatf("v%0d_read", i), vecs[i].expRead);
        end

        // Bus write and local write to register 3 on the same commit edge.
        p0 = pulseCnt;
        busAddr(8'h03);
        cs_n = 1'b0; ad_n = 1'b1; tbDrv = 8'h22; tbOe = 1'b1; wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1;
        tick(2);
        loc_we = 1'b1; loc_addr = 4'h3; loc_wdata = 8'h11;
        tick(1);
        loc_we = 1'b0;
        tick(3);
        tbOe = 1'b0; cs_n = 1'b1;
        tick(3);
        check("clash_pulses", 32'(pulseCnt - p0), 32'd1);
        busAddr(8'h03);
        busRead("clash_read", 8'h22);

        // Local-only write: no bus_wr pulse.
        p0 = pulseCnt;
        loc_we = 1'b1; loc_addr = 4'h7; loc_wdata = 8'h99;
        tick(1);
        loc_we = 1'b0;
        tick(2);
        check("loc_pulses", 32'(pulseCnt - p0), 32'd0);
        busAddr(8'h07);
        busRead("loc_read", 8'h99);

        // Local update while a read is being driven shows up one cycle later.
        busAddr(8'h07);
        cs_n = 1'b0; rd_n = 1'b0;
        tick(3);
        check("upd_before", 32'(io_port), 32'h99);
        loc_we = 1'b1; loc_addr = 4'h7; loc_wdata = 8'h42;
        tick(1);
        loc_we = 1'b0;
        check("upd_same", 32'(io_port), 32'h99);
        tick(1);
        check("upd_after", 32'(io_port), 32'h42);
        rd_n = 1'b1;
        tick(3);
        check("upd_rel", 32'(io_port), 32'(RELEASED));
        cs_n = 1'b1;
        tick(3);

        // Deselect during a write cycle discards the write.
        p0 = pulseCnt;
        busAddr(8'h05);
        cs_n = 1'b0; ad_n = 1'b1; tbDrv = 8'hEE; tbOe = 1'b1; wr_n = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(4);
        wr_n = 1'b1;
        tick(4);
        tbOe = 1'b0;
        check("abort_pulses", 32'(pulseCnt - p0), 32'd0);
        busAddr(8'h05);
        busRead("abort_read", 8'hA7);

        // Read and write strobes together: sticky protocol error.
        check("proto_pre", 32'(proto_err), 32'd0);
        cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0; wr_n = 1'b0;
        tick(4);
        check("proto_set", 32'(proto_err), 32'd1);
        check("proto_io", 32'(io_port), 32'(RELEASED));
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
        tick(4);
        busAddr(8'h05);
        busRead("proto_read", 8'hA7);
        check("proto_sticky", 32'(proto_err), 32'd1);

        // Reset in the middle of a driven read releases the bus on the next edge.
        busAddr(8'h05);
        cs_n = 1'b0; rd_n = 1'b0;
        tick(3);
        check("mid_drive", 32'(io_port), 32'hA7);
        reset = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
        tick(1);
        check("mid_rel", 32'(io_port), 32'(RELEASED));
        check("mid_proto", 32'(proto_err), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("mid_buswr", 32'(bus_wr), 32'd0);
        busAddr(8'h05);
        busRead("mid_reg5", 8'h00);

`ifdef ADDR_AUTOINC_EN
        // Consecutive writes without a new address wrap from the last register to 0.
        busAddr(8'h0B);
        busWrite(8'h01);
        busWrite(8'h02);
        busAddr(8'h0B);
        busRead("inc_last", 8'h01);
        busAddr(8'h00);
        busRead("inc_wrap", 8'h02);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
